offset_config_loader: RTL and testbench
=======================================

Name: offset_config_loader

Overview:
- Boot-time and on-demand sequencer that programs every thread's Programmed Offset (PO) entries and Default Offset (DO) in the Addressing unit.
- Accepts a word stream and issues each word as a write on the Addressing external write port, only in the target thread's slot.
- Shares that write port with the pipeline's normal write path; the pipeline always has priority.

Parameters:
- WRITE_WORD_WIDTH, 36, system word width (width of write data)
- WRITE_ADDR_WIDTH, 12, width of the write address space
- THREAD_COUNT, 8, number of hardware threads
- THREAD_COUNT_WIDTH, 3, width of a thread index
- PO_ENTRY_COUNT, 4, PO entries per operand per thread
- PO_ENTRY_WIDTH, 2, width of an entry index
- A_PO_ADDR_BASE, 0, write address of A PO entry 0
- B_PO_ADDR_BASE, 0, write address of B PO entry 0
- DA_PO_ADDR_BASE, 0, write address of DA PO entry 0
- DB_PO_ADDR_BASE, 0, write address of DB PO entry 0
- DO_ADDR, 0, write address of the DO register

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a full load
- current_thread  in  THREAD_COUNT_WIDTH  thread that owns the write port in the next cycle
- cfg_data  in  WRITE_WORD_WIDTH  configuration stream word
- cfg_valid  in  1  cfg_data is valid
- cfg_ready  out  1  loader accepts cfg_data this cycle
- pipe_write_addr  in  WRITE_ADDR_WIDTH  pipeline write address
- pipe_write_data  in  WRITE_WORD_WIDTH  pipeline write data
- pipe_write_valid  in  1  pipeline write wants the port in the next cycle
- write_addr  out  WRITE_ADDR_WIDTH  registered, to Addressing
- write_data  out  WRITE_WORD_WIDTH  registered, to Addressing
- write_valid  out  1  registered write strobe
- write_is_loader  out  1  registered; current write came from the loader
- busy  out  1  a load is in progress
- done  out  1  one-cycle pulse when the load completes

Behaviour:
- Reset (asynchronous, any time, including mid-load):
  - state becomes IDLE and all counters clear.
  - cfg_ready, write_valid, write_is_loader, busy and done are all 0.
  - write_addr and write_data are 0.
  - The partial load is abandoned. It is not resumed; a new start is required.
- Stream order:
  - Threads run 0..THREAD_COUNT-1.
  - Within a thread, operands run A, B, DA, DB; each operand supplies entries 0..PO_ENTRY_COUNT-1.
  - The DO word follows the operands.
  - Words per thread = 4*PO_ENTRY_COUNT+1.
- Target address:
  - PO word: operand base + entry_idx, truncated to WRITE_ADDR_WIDTH.
  - DO word: DO_ADDR.
- State IDLE:
  - busy=0 and cfg_ready=0.
  - start=1 moves to FETCH and sets busy=1 in the next cycle.
- State FETCH:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready, latch the word and move to SLOT; cfg_ready drops in the next cycle.
- State SLOT:
  - cfg_ready=0.
  - The loader issues when current_thread==thread_idx and pipe_write_valid==0.
  - The write outputs register the loader word and address, with write_valid=1 and write_is_loader=1, in the following cycle.
  - Counters advance on issue: entry, then operand, then thread.
  - After the last word of the last thread, move to DONE; otherwise return to FETCH.
- State DONE:
  - done=1 for one cycle, then IDLE; busy=0 from IDLE onward.
  - The final write and the done pulse are on the same clock edge.
- Write-port mux (registered, every cycle):
  - If pipe_write_valid: the outputs take the pipe values, write_valid=1, write_is_loader=0.
  - Else if the loader is issuing: the outputs take the loader values.
  - Otherwise write_valid=0 and write_is_loader=0; write_addr and write_data hold their previous values.
- Pipeline writes pass through with a 1-cycle latency in all states, including IDLE.
- Slot rules:
  - A pipeline write in the matching slot defers the loader to that thread's next slot.
  - The loader is never dropped and never stalls the pipeline.
- start while busy is ignored; an in-flight load is unaffected.
- cfg_valid outside FETCH is ignored; no word is consumed.
- Minimum load time is THREAD_COUNT*(4*PO_ENTRY_COUNT+1) loader writes. With round-robin threads, at most one loader write occurs per THREAD_COUNT cycles per thread.

Test Plan:
- Setup: THREAD_COUNT=2, PO_ENTRY_COUNT=2, A/B/DA/DB bases 0x200/0x204/0x208/0x20C, DO_ADDR=0x210; current_thread alternates 0,1; cfg_valid always 1 with data=index 0..17.
  - Expected: 18 loader writes; thread 0 words 0..8 to 0x200,0x201,0x204,0x205,0x208,0x209,0x20C,0x20D,0x210, each with current_thread 0 in the cycle before issue; thread 1 words 9..17 to the same sequence.
  - done pulses once, coincident with the write of word 17; busy falls the cycle after.
- Pipeline collision:
  - Stimulus: same setup, pipe_write_valid=1 (addr 0x050, data 0xABC) in thread 0's first slot.
  - Expected: the next cycle shows 0x050/0xABC with write_is_loader=0; word 0 issues at thread 0's next slot; no word lost.
- Stream stall:
  - Stimulus: cfg_valid held 0 for 10 cycles after word 3.
  - Expected: cfg_ready stays 1, no loader writes, busy stays 1; the load then completes with correct addresses.
- Second start: a start pulse mid-load -> no restart; the total write count is still 18.
- Reset mid-load: assert reset after word 5 -> all outputs 0 immediately. A new start reloads from thread 0, entry 0, address 0x200.
- Idle pass-through: IDLE, pipe write to 0x123 -> the output appears 1 cycle later; busy=0 and done=0 throughout.

Source files
------------

// File: rtl/offset_config_loader_if.sv
// Bundles the configuration stream, the pipeline write request and the shared
// Addressing write port seen by offset_config_loader.
interface offset_config_loader_if #(
  parameter int WRITE_WORD_WIDTH   = 36,
  parameter int WRITE_ADDR_WIDTH   = 12,
  parameter int THREAD_COUNT_WIDTH = 3
);
  logic                          start;
  logic [THREAD_COUNT_WIDTH-1:0] current_thread;
  logic [WRITE_WORD_WIDTH-1:0]   cfg_data;
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [WRITE_ADDR_WIDTH-1:0]   pipe_write_addr;
  logic [WRITE_WORD_WIDTH-1:0]   pipe_write_data;
  logic                          pipe_write_valid;
  logic [WRITE_ADDR_WIDTH-1:0]   write_addr;
  logic [WRITE_WORD_WIDTH-1:0]   write_data;
  logic                          write_valid;
  logic                          write_is_loader;
  logic                          busy;
  logic                          done;

  modport master (
    output start, current_thread, cfg_data, cfg_valid,
           pipe_write_addr, pipe_write_data, pipe_write_valid,
    input  cfg_ready, write_addr, write_data, write_valid, write_is_loader,
           busy, done
  );

  modport slave (
    input  start, current_thread, cfg_data, cfg_valid,
           pipe_write_addr, pipe_write_data, pipe_write_valid,
    output cfg_ready, write_addr, write_data, write_valid, write_is_loader,
           busy, done
  );
endinterface

// File: rtl/offset_config_loader.sv
// Streams PO/DO configuration words into the Addressing write port, one word
// per owning-thread slot, always yielding the port to pipeline writes.
module offset_config_loader #(
  parameter int WRITE_WORD_WIDTH   = 36,
  parameter int WRITE_ADDR_WIDTH   = 12,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3,
  parameter int PO_ENTRY_COUNT     = 4,
  parameter int PO_ENTRY_WIDTH     = 2,
  parameter int A_PO_ADDR_BASE     = 0,
  parameter int B_PO_ADDR_BASE     = 0,
  parameter int DA_PO_ADDR_BASE    = 0,
  parameter int DB_PO_ADDR_BASE    = 0,
  parameter int DO_ADDR            = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  offset_config_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SLOT,
    S_DONE
  } state_t;

  // Operand phases 0..3 are A, B, DA, DB; phase 4 is the single DO word.
  localparam logic [2:0] OPER_DO = 3'd4;
  localparam logic [PO_ENTRY_WIDTH-1:0] LAST_ENTRY =
    PO_ENTRY_WIDTH'(PO_ENTRY_COUNT - 1);
  localparam logic [THREAD_COUNT_WIDTH-1:0] LAST_THREAD =
    THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);

  state_t                        state_q, state_d;
  logic [THREAD_COUNT_WIDTH-1:0] thread_q, thread_d;
  logic [PO_ENTRY_WIDTH-1:0]     entry_q, entry_d;
  logic [2:0]                    oper_q, oper_d;
  logic [WRITE_WORD_WIDTH-1:0]   word_q, word_d;
  logic [WRITE_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [WRITE_WORD_WIDTH-1:0]   wdata_q, wdata_d;
  logic                          wvalid_q, wvalid_d;
  logic                          wloader_q, wloader_d;
  logic                          issue;
  logic [WRITE_ADDR_WIDTH-1:0]   loader_addr;

  always_comb begin
    case (oper_q)
      3'd0:    loader_addr = WRITE_ADDR_WIDTH'(A_PO_ADDR_BASE)  + WRITE_ADDR_WIDTH'(entry_q);
      3'd1:    loader_addr = WRITE_ADDR_WIDTH'(B_PO_ADDR_BASE)  + WRITE_ADDR_WIDTH'(entry_q);
      3'd2:    loader_addr = WRITE_ADDR_WIDTH'(DA_PO_ADDR_BASE) + WRITE_ADDR_WIDTH'(entry_q);
      3'd3:    loader_addr = WRITE_ADDR_WIDTH'(DB_PO_ADDR_BASE) + WRITE_ADDR_WIDTH'(entry_q);
      default: loader_addr = WRITE_ADDR_WIDTH'(DO_ADDR);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    thread_d = thread_q;
    entry_d  = entry_q;
    oper_d   = oper_q;
    word_d   = word_q;
    issue    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_FETCH;
          thread_d = '0;
          entry_d  = '0;
          oper_d   = '0;
        end
      end
      S_FETCH: begin
        if (bus.cfg_valid) begin
          word_d  = bus.cfg_data;
          state_d = S_SLOT;
        end
      end
      S_SLOT: begin
        // A pipeline write in our slot simply pushes us to the next round.
        if ((bus.current_thread == thread_q) && !bus.pipe_write_valid) begin
          issue   = 1'b1;
          state_d = S_FETCH;
          if (oper_q == OPER_DO) begin
            oper_d  = '0;
            entry_d = '0;
            if (thread_q == LAST_THREAD) begin
              thread_d = '0;
              state_d  = S_DONE;
            end else begin
              thread_d = thread_q + 1'b1;
            end
          end else if (entry_q == LAST_ENTRY) begin
            entry_d = '0;
            oper_d  = oper_q + 3'd1;
          end else begin
            entry_d = entry_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shared write port: pipeline first, loader second, otherwise hold addr/data.
  always_comb begin
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wvalid_d  = 1'b0;
    wloader_d = 1'b0;
    if (bus.pipe_write_valid) begin
      waddr_d  = bus.pipe_write_addr;
      wdata_d  = bus.pipe_write_data;
      wvalid_d = 1'b1;
    end else if (issue) begin
      waddr_d   = loader_addr;
      wdata_d   = word_q;
      wvalid_d  = 1'b1;
      wloader_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      thread_q  <= '0;
      entry_q   <= '0;
      oper_q    <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      wloader_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      thread_q  <= thread_d;
      entry_q   <= entry_d;
      oper_q    <= oper_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wvalid_q  <= wvalid_d;
      wloader_q <= wloader_d;
    end
  end

  // The buffered word is only read after a fresh handshake, so it needs no reset.
  always_ff @(posedge clock) begin
    word_q <= word_d;
  end

  assign bus.cfg_ready       = (state_q == S_FETCH);
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.done            = (state_q == S_DONE);
  assign bus.write_addr      = waddr_q;
  assign bus.write_data      = wdata_q;
  assign bus.write_valid     = wvalid_q;
  assign bus.write_is_loader = wloader_q;

endmodule

// File: tb/tb_offset_config_loader.sv
// Bench for offset_config_loader: idle pass-through table, directed load
// scenarios and randomized loads, all checked against a word-level model.
module tb_offset_config_loader;
  localparam int WW  = 36;
  localparam int AW  = 12;
  localparam int TC  = 2;
  localparam int TW  = 1;
  localparam int PE  = 2;
  localparam int PW  = 1;
  localparam int WPT = 4 * PE + 1;
  localparam int N   = TC * WPT;
  localparam int LIMIT = 3000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  offset_config_loader_if #(
    .WRITE_WORD_WIDTH(WW), .WRITE_ADDR_WIDTH(AW), .THREAD_COUNT_WIDTH(TW)
  ) bus ();

  offset_config_loader #(
    .WRITE_WORD_WIDTH(WW), .WRITE_ADDR_WIDTH(AW),
    .THREAD_COUNT(TC), .THREAD_COUNT_WIDTH(TW),
    .PO_ENTRY_COUNT(PE), .PO_ENTRY_WIDTH(PW),
    .A_PO_ADDR_BASE(32'h200), .B_PO_ADDR_BASE(32'h204),
    .DA_PO_ADDR_BASE(32'h208), .DB_PO_ADDR_BASE(32'h20C),
    .DO_ADDR(32'h210)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a load is a list of N words; the loader holds at most
  // one accepted-but-unwritten word, written in the owning thread's free slot.
  bit            m_active, m_done;
  int            acc, iss;
  logic [WW-1:0] words[$];
  logic          exp_wv, exp_wl;
  logic [AW-1:0] exp_wa;
  logic [WW-1:0] exp_wd;
  logic [AW-1:0] seen_addr[$];

  typedef struct {
    logic          pv;
    logic [AW-1:0] pa;
    logic [WW-1:0] pd;
    logic          ewv;
    logic [AW-1:0] ewa;
    logic [WW-1:0] ewd;
  } vec_t;
  vec_t tab[5];
  logic [AW-1:0] addr_tab[WPT];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic int thr(input int k);
    return k / WPT;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int k);
    int w;
    w = k % WPT;
    if (w == 4 * PE) return AW'(32'h210);
    return AW'(32'h200 + 4 * (w / PE) + (w % PE));
  endfunction

  function automatic bit exp_ready();
    return m_active && !m_done && (acc == iss) && (iss < N);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    acc      = 0;
    iss      = 0;
    words.delete();
    exp_wv = 1'b0;
    exp_wl = 1'b0;
    exp_wa = '0;
    exp_wd = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_write_valid"}, 64'(bus.write_valid), 64'(exp_wv));
    chk({tag, "_write_is_loader"}, 64'(bus.write_is_loader), 64'(exp_wl));
    chk({tag, "_write_addr"}, 64'(bus.write_addr), 64'(exp_wa));
    chk({tag, "_write_data"}, 64'(bus.write_data), 64'(exp_wd));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(m_active));
    chk({tag, "_done"}, 64'(bus.done), 64'(m_done));
    chk({tag, "_cfg_ready"}, 64'(bus.cfg_ready), 64'(exp_ready()));
  endtask

  task automatic tick();
    logic s, cv, pv, rs;
    logic [TW-1:0] ct;
    logic [AW-1:0] pa;
    logic [WW-1:0] pd, cd;
    bit acc_now, iss_now;
    s  = bus.start;     cv = bus.cfg_valid;      pv = bus.pipe_write_valid;
    rs = reset;         ct = bus.current_thread; pa = bus.pipe_write_addr;
    pd = bus.pipe_write_data; cd = bus.cfg_data;
    @(posedge clock);
    if (rs) begin
      model_reset();
    end else begin
      acc_now = exp_ready() && cv;
      iss_now = m_active && (acc > iss) && (ct == TW'(thr(iss))) && !pv;
      exp_wv = pv || iss_now;
      exp_wl = iss_now;
      if (pv) begin
        exp_wa = pa;
        exp_wd = pd;
      end else if (iss_now) begin
        exp_wa = addr_of(iss);
        exp_wd = words[iss];
      end
      if (m_done) begin
        m_active = 1'b0;
        m_done   = 1'b0;
      end else if (!m_active) begin
        if (s) begin
          m_active = 1'b1;
          acc = 0;
          iss = 0;
          words.delete();
        end
      end else begin
        if (acc_now) begin
          words.push_back(cd);
          acc++;
        end
        if (iss_now) begin
          iss++;
          if (iss == N) m_done = 1'b1;
        end
      end
    end
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle_inputs();
    bus.start            = 1'b0;
    bus.cfg_valid        = 1'b0;
    bus.cfg_data         = '0;
    bus.pipe_write_valid = 1'b0;
    bus.pipe_write_addr  = '0;
    bus.pipe_write_data  = '0;
  endtask

  // mode: 0 plain, 1 pipeline collision, 2 stream stall, 3 second start,
  //       4 randomized, 5 abandon after word 5 has been written
  task automatic run_load(input int mode, output int nwr, output int ndone);
    int  cyc;
    int  stall;
    bit  coll_done, restarted;
    logic [TW-1:0] ct;
    cyc = 0; stall = 0; coll_done = 0; restarted = 0; ct = '0;
    nwr = 0; ndone = 0;
    seen_addr.delete();
    bus.start     = 1'b1;
    bus.cfg_valid = 1'b1;
    tick();
    bus.start = 1'b0;
    while (m_active && cyc < LIMIT) begin
      if (mode == 5 && iss == 6) break;
      cyc++;
      ct = (mode == 4) ? TW'($urandom_range(0, TC - 1)) : TW'(cyc % TC);
      bus.current_thread = ct;
      bus.cfg_data  = (mode == 4) ? WW'({$urandom(), $urandom()}) : WW'(acc);
      bus.cfg_valid = 1'b1;
      if (mode == 2 && acc >= 4 && stall < 10) begin
        bus.cfg_valid = 1'b0;
        stall++;
      end
      if (mode == 4) bus.cfg_valid = ($urandom_range(0, 9) < 7);
      bus.pipe_write_valid = 1'b0;
      if (mode == 1 && !coll_done && acc == 1 && iss == 0 && ct == '0) begin
        bus.pipe_write_valid = 1'b1;
        bus.pipe_write_addr  = AW'(32'h050);
        bus.pipe_write_data  = WW'(32'hABC);
        coll_done = 1'b1;
      end
      if (mode == 4 && $urandom_range(0, 3) == 0) begin
        bus.pipe_write_valid = 1'b1;
        bus.pipe_write_addr  = AW'($urandom());
        bus.pipe_write_data  = WW'({$urandom(), $urandom()});
      end
      bus.start = 1'b0;
      if (mode == 3 && iss == 7 && !restarted) begin
        bus.start = 1'b1;
        restarted = 1'b1;
      end
      if (mode == 4 && $urandom_range(0, 29) == 0) bus.start = 1'b1;
      tick();
      if (bus.write_valid && bus.write_is_loader) begin
        seen_addr.push_back(bus.write_addr);
        nwr++;
      end
      if (bus.done) begin
        ndone++;
        chk("done_with_last_write", 64'(nwr), 64'(N));
      end
    end
    idle_inputs();
    if (cyc >= LIMIT) chk("load_timeout", 64'(cyc), 64'(0));
  endtask

  task automatic check_load(input string tag, input int nwr, input int ndone);
    chk({tag, "_write_count"}, 64'(nwr), 64'(N));
    chk({tag, "_done_count"}, 64'(ndone), 64'(1));
    for (int i = 0; i < seen_addr.size() && i < N; i++)
      chk({tag, "_addr_order"}, 64'(seen_addr[i]), 64'(addr_tab[i % WPT]));
    tick();
    chk({tag, "_busy_after"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    int nwr, ndone;
    addr_tab = '{AW'(32'h200), AW'(32'h201), AW'(32'h204), AW'(32'h205),
                 AW'(32'h208), AW'(32'h209), AW'(32'h20C), AW'(32'h20D),
                 AW'(32'h210)};
    tab[0] = '{1'b1, AW'(32'h123), WW'(32'h0AA),    1'b1, AW'(32'h123), WW'(32'h0AA)};
    tab[1] = '{1'b0, AW'(32'h3FF), WW'(32'h055),    1'b0, AW'(32'h123), WW'(32'h0AA)};
    tab[2] = '{1'b1, AW'(32'hFFF), {WW{1'b1}},      1'b1, AW'(32'hFFF), {WW{1'b1}}};
    tab[3] = '{1'b1, AW'(32'h000), WW'(32'h0),      1'b1, AW'(32'h000), WW'(32'h0)};
    tab[4] = '{1'b0, AW'(32'h555), WW'(32'h777),    1'b0, AW'(32'h000), WW'(32'h0)};

    idle_inputs();
    bus.current_thread = '0;
    model_reset();
    #1;
    check_outputs("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Idle pass-through: one cycle of latency, loader flags stay low.
    for (int i = 0; i < 5; i++) begin
      bus.pipe_write_valid = tab[i].pv;
      bus.pipe_write_addr  = tab[i].pa;
      bus.pipe_write_data  = tab[i].pd;
      bus.cfg_valid        = 1'b1;
      tick();
      chk("idle_valid", 64'(bus.write_valid), 64'(tab[i].ewv));
      chk("idle_addr", 64'(bus.write_addr), 64'(tab[i].ewa));
      chk("idle_data", 64'(bus.write_data), 64'(tab[i].ewd));
      chk("idle_is_loader", 64'(bus.write_is_loader), 64'(0));
      chk("idle_busy", 64'(bus.busy), 64'(0));
      chk("idle_done", 64'(bus.done), 64'(0));
    end
    idle_inputs();
    tick();

    run_load(0, nwr, ndone);  check_load("plain", nwr, ndone);
    run_load(1, nwr, ndone);  check_load("collision", nwr, ndone);
    run_load(2, nwr, ndone);  check_load("stall", nwr, ndone);
    run_load(3, nwr, ndone);  check_load("second_start", nwr, ndone);

    // Abandon a load with an asynchronous reset between clock edges.
    run_load(5, nwr, ndone);
    chk("abort_progress", 64'(nwr), 64'(6));
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    tick();
    reset = 1'b0;
    tick();
    run_load(0, nwr, ndone);  check_load("reload", nwr, ndone);

    for (int r = 0; r < 3; r++) begin
      run_load(4, nwr, ndone);
      check_load("random", nwr, ndone);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
